// File: rtl/text_buffer_ram.sv
// N-character text store for the on-screen overlay: a valid/ready stream load
// with space padding, a bulk clear, and a 1-cycle registered read port.
module text_buffer_ram #(
  parameter int                N_CHARS    = 16,
  parameter int                CHAR_W     = 7,
  parameter int                ADDR_W     = 8,
  parameter logic [CHAR_W-1:0] SPACE_CODE = CHAR_W'('h20),
  parameter bit                PAD_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              clear_req,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              wr_last,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CHAR_W-1:0] char_code
);

  localparam int                IDX_W    = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_CHARS - 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N_CHARS);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, PAD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [CHAR_W-1:0]   ram [N_CHARS];
  logic                we;
  logic [CHAR_W-1:0]   wdata;
  logic                hs;
  logic                at_last;

  assign hs      = wr_valid && wr_ready;
  assign at_last = (wr_ptr == LAST_PTR);

  // A write in the reset cycle is suppressed so an abort leaves the RAM as it was.
  always_comb begin
    we    = 1'b0;
    wdata = SPACE_CODE;
    case (state)
      CLEAR, PAD: we = 1'b1;
      LOAD: begin
        we    = hs;
        wdata = wr_char;
      end
      default: we = 1'b0;
    endcase
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state  <= CLEAR;
            busy   <= 1'b1;
            wr_ptr <= '0;
          end else if (load_start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            wr_ready <= 1'b1;
            wr_ptr   <= '0;
          end
        end
        CLEAR, PAD: begin
          if (at_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
          end
        end
        LOAD: begin
          if (hs) begin
            if (at_last || (wr_last && !PAD_EN)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              wr_ready <= 1'b0;
              done     <= 1'b1;
            end else if (wr_last) begin
              state    <= PAD;
              wr_ready <= 1'b0;
              wr_ptr   <= wr_ptr + ADDR_W'(1);
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram[wr_ptr[IDX_W-1:0]] <= wdata;
  end

  // Non-blocking RAM update gives read-before-write on a same-cell collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code <= SPACE_CODE;
    end else if ({1'b0, rd_addr} < N_EXT) begin
      char_code <= ram[rd_addr[IDX_W-1:0]];
    end else begin
      char_code <= SPACE_CODE;
    end
  end

endmodule
